shift_sched_arbiter: RTL

- Round-robin scheduler that shares one shift_register_variable instance among NUM_REQ requesters.
- Each request carries a shift count (0-15), a direction and up to 15 serial bits. The block issues them as single-bit shifts, one per cycle.
- When a request's shifts complete, the block captures the register contents and returns them to the requester on a valid/ready response channel.
- Sits between requester logic and the shift register; it is the only driver of the register's shift_count, dir and serial_in inputs.

---
 rtl/shift_sched_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shift_sched_arbiter.sv
// Round-robin scheduler sharing one variable shift register among NUM_REQ requesters.
// Define SHIFT_SCHED_STATS_EN to add the saturating shift_total / grant_total counters.
module shift_sched_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_count,
  input  logic [NUM_REQ-1:0]   req_dir,
  input  logic [15*NUM_REQ-1:0] req_data,
  output logic [3:0]           sr_shift_count,
  output logic                 sr_dir,
  output logic                 sr_serial_in,
  input  logic [WIDTH-1:0]     sr_q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [WIDTH-1:0]     rsp_q,
  output logic                 busy
`ifdef SHIFT_SCHED_STATS_EN
  ,
  output logic [15:0]          shift_total,
  output logic [15:0]          grant_total
`endif
);

  // state     | meaning
  // S_IDLE    | arbitrate and accept one request
  // S_SHIFT   | one single-bit shift per cycle until remaining hits terminal count
  // S_CAPTURE | register settled after last shift; sample sr_q into rsp_q
  // S_RESP    | hold response until rsp_ready
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr_next;
  logic               found;
  logic               accept;
  logic [NUM_REQ-1:0] vshift;
  int                 k;
  logic [3:0]         sel_count;
  logic               sel_dir;
  logic [14:0]        sel_data;
  logic [3:0]         remaining;
  logic               dir_l;
  logic [14:0]        data_l;
  logic               dir_last;
  logic               serial_last;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    k      = 0;
    vshift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      vshift = req_valid >> k;
      if (!found && vshift[0]) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end

  always_comb begin
    sel_count = '0;
    sel_dir   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_count = req_count[4*i +: 4];
        sel_dir   = req_dir[i];
        sel_data  = req_data[15*i +: 15];
      end
    end
  end

  assign accept   = (state == S_IDLE) && found;
  assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign busy     = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NUM_REQ'(1) << winner;
  end

  // Outside SHIFT the serial/dir lines park on the last driven values.
  assign sr_shift_count = (state == S_SHIFT) ? 4'd1 : 4'd0;
  assign sr_dir         = (state == S_SHIFT) ? dir_l : dir_last;
  assign sr_serial_in   = (state == S_SHIFT) ? data_l[0] : serial_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      remaining   <= '0;
      dir_l       <= 1'b0;
      data_l      <= '0;
      dir_last    <= 1'b0;
      serial_last <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            remaining <= sel_count;
            dir_l     <= sel_dir;
            data_l    <= sel_data;
            rsp_id    <= winner;
            ptr       <= ptr_next;
            state     <= (sel_count != 4'd0) ? S_SHIFT : S_CAPTURE;
          end
        end
        S_SHIFT: begin
          data_l      <= data_l >> 1;
          remaining   <= remaining - 4'd1;
          dir_last    <= dir_l;
          serial_last <= data_l[0];
          if (remaining == 4'd1) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_q     <= sr_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHIFT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_total <= '0;
      grant_total <= '0;
    end else begin
      if (state == S_SHIFT && shift_total != 16'hFFFF) shift_total <= shift_total + 16'd1;
      if (accept && grant_total != 16'hFFFF) grant_total <= grant_total + 16'd1;
    end
  end
`endif

endmodule
